// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter: one-hot grant, priority rotates to the
// requester after the most recently granted one.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [LW-1:0] last;
    logic [N-1:0]  w_grant_nxt;
    logic [LW-1:0] w_last_nxt;

    // Search starts one past the last winner and wraps, so a port that just
    // won is considered last and can only win again if it is alone.
    always_comb begin
        logic found;
        int   idx;
        w_grant_nxt = '0;
        w_last_nxt  = last;
        found       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found              = 1'b1;
                w_grant_nxt[idx]   = 1'b1;
                w_last_nxt         = LW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant <= '0;
            last  <= LW'(N - 1);
        end else begin
            grant <= w_grant_nxt;
            last  <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter at N=2 and N=4; expected grants are queued
// when a request is driven and checked one edge later.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req2;
    logic [1:0] grant2;
    logic [3:0] req4;
    logic [3:0] grant4;

    int n_chk;
    int n_err;

    logic [3:0] exp_grant_q[$];
    logic [3:0] exp_last_q[$];

    rr_arbiter #(.N(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req2),
        .grant (grant2)
    );

    rr_arbiter #(.N(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .req   (req4),
        .grant (grant4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive a request on the N=2 arbiter, queue its expected result, then
    // pop and compare one edge later.
    task automatic step2(input string tag, input logic [1:0] r,
                         input logic [1:0] eg, input logic el);
        logic [3:0] g;
        logic [3:0] l;
        req2 = r;
        exp_grant_q.push_back({2'b00, eg});
        exp_last_q.push_back({3'b000, el});
        @(posedge clk);
        #1;
        g = exp_grant_q.pop_front();
        l = exp_last_q.pop_front();
        check({tag, ".grant"}, {2'b00, grant2}, g);
        check({tag, ".last"},  {3'b000, dut.last}, l);
    endtask

    task automatic step4(input string tag, input logic [3:0] r,
                         input logic [3:0] eg, input logic [1:0] el);
        logic [3:0] g;
        logic [3:0] l;
        req4 = r;
        exp_grant_q.push_back(eg);
        exp_last_q.push_back({2'b00, el});
        @(posedge clk);
        #1;
        g = exp_grant_q.pop_front();
        l = exp_last_q.pop_front();
        check({tag, ".grant"}, grant4, g);
        check({tag, ".last"},  {2'b00, dut4.last}, l);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        req2  = 2'b00;
        req4  = 4'b0000;

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.grant2", {2'b00, grant2}, 4'b0000);
        check("rst.last2",  {3'b000, dut.last}, 4'b0001);
        check("rst.grant4", grant4, 4'b0000);
        check("rst.last4",  {2'b00, dut4.last}, 4'b0011);
        rst = 1'b0;

        step2("idle", 2'b00, 2'b00, 1'b1);

        step2("single0", 2'b01, 2'b01, 1'b0);
        step2("single1", 2'b10, 2'b10, 1'b1);
        step2("release", 2'b00, 2'b00, 1'b1);

        step2("cont0", 2'b11, 2'b01, 1'b0);
        step2("cont1", 2'b11, 2'b10, 1'b1);
        step2("cont2", 2'b11, 2'b01, 1'b0);
        step2("cont3", 2'b11, 2'b10, 1'b1);

        step2("alt0", 2'b01, 2'b01, 1'b0);
        step2("alt1", 2'b10, 2'b10, 1'b1);
        step2("alt2", 2'b01, 2'b01, 1'b0);

        // Sole requester keeps winning
        step2("solo", 2'b01, 2'b01, 1'b0);

        // Asynchronous reset between edges while grant=01
        #2;
        rst = 1'b1;
        #1;
        check("arst.grant2", {2'b00, grant2}, 4'b0000);
        check("arst.last2",  {3'b000, dut.last}, 4'b0001);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step2("post_rst", 2'b01, 2'b01, 1'b0);
        step2("withdraw", 2'b00, 2'b00, 1'b0);

        // N=4: full contention rotates 0,1,2,3,0
        step4("q0", 4'b1111, 4'b0001, 2'd0);
        step4("q1", 4'b1111, 4'b0010, 2'd1);
        step4("q2", 4'b1111, 4'b0100, 2'd2);
        step4("q3", 4'b1111, 4'b1000, 2'd3);
        step4("q4", 4'b1111, 4'b0001, 2'd0);

        step4("q_set1", 4'b0010, 4'b0010, 2'd1);
        step4("q_sk0",  4'b1010, 4'b1000, 2'd3);
        step4("q_sk1",  4'b1010, 4'b0010, 2'd1);
        step4("q_idle", 4'b0000, 4'b0000, 2'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
